// File: rtl/branch_pkg.sv
// Shared branch-prediction types: PC width, instruction size and the in-flight prediction record.
// Reused by fetch, predictor glue and the resolve unit.
package branch_pkg;
  localparam int PC_W        = 16;
  localparam int INSTR_BYTES = 2;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
  } branch_rec_t;

  // Fall-through address; wraps modulo 2^PC_W
  function automatic logic [PC_W-1:0] seq_next_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(INSTR_BYTES);
  endfunction
endpackage

// File: rtl/branch_resolve_unit_if.sv
// Decode push, execute resolve and predictor-update/redirect signals of the branch resolve unit.
// The master side is the pipeline (decode/execute/fetch); the slave side is the resolve unit.
interface branch_resolve_unit_if;
  import branch_pkg::*;

  logic            push_valid;
  logic [PC_W-1:0] push_pc;
  logic            push_pred_taken;
  logic [PC_W-1:0] push_pred_target;
  logic            push_ready;

  logic            res_valid;
  logic            res_taken;
  logic [PC_W-1:0] res_target;

  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;
  logic            upd_en;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;

  modport master (
    output push_valid, push_pc, push_pred_taken, push_pred_target,
    output res_valid, res_taken, res_target,
    input  push_ready, mispredict, redirect_pc,
    input  upd_en, upd_pc, upd_taken, upd_target
  );

  modport slave (
    input  push_valid, push_pc, push_pred_taken, push_pred_target,
    input  res_valid, res_taken, res_target,
    output push_ready, mispredict, redirect_pc,
    output upd_en, upd_pc, upd_taken, upd_target
  );
endinterface

// File: rtl/bp_fifo.sv
// In-order queue of branch prediction records with push, pop and whole-queue flush.
// Flush has priority over push and pop in the same cycle.
module bp_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  branch_rec_t      din,
  output branch_rec_t      dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;
  branch_rec_t      mem_q [DEPTH];

  always_comb begin
    full    = (count_q == (PTR_W+1)'(DEPTH));
    empty   = (count_q == '0);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue can still accept
    do_push = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/branch_resolve_unit.sv
// Compares queued branch predictions against execute outcomes, drives the predictor update and
// fetch redirect, and keeps saturating branch/mispredict statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  branch_resolve_unit_if.slave bus,
  output logic [PTR_W:0]     occupancy,
  output logic [CNT_W-1:0]   br_cnt,
  output logic [CNT_W-1:0]   mp_cnt,
  output logic               err_underflow,
  output logic               err_overflow
);
  branch_rec_t     push_rec, head;
  logic            fifo_full, fifo_empty;
  logic            res_fire, mp_now;

  logic            mispredict_q, mispredict_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            upd_en_q, upd_en_d;
  logic [PC_W-1:0] upd_pc_q, upd_pc_d;
  logic            upd_taken_q, upd_taken_d;
  logic [PC_W-1:0] upd_target_q, upd_target_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
  logic            err_underflow_q, err_underflow_d;
  logic            err_overflow_q, err_overflow_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign push_rec = '{pc: bus.push_pc, pred_taken: bus.push_pred_taken,
                      pred_target: bus.push_pred_target};

  // A mispredict flushes the queue, which also discards any same-cycle push
  bp_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.push_valid),
    .pop   (res_fire),
    .flush (mp_now),
    .din   (push_rec),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  always_comb begin
    res_fire = bus.res_valid && !fifo_empty;
    mp_now   = res_fire && ((head.pred_taken != bus.res_taken) ||
                            (bus.res_taken && (head.pred_target != bus.res_target)));

    mispredict_d    = mp_now;
    redirect_pc_d   = '0;
    upd_en_d        = res_fire;
    upd_pc_d        = upd_pc_q;
    upd_taken_d     = upd_taken_q;
    upd_target_d    = upd_target_q;
    br_cnt_d        = br_cnt_q;
    mp_cnt_d        = mp_cnt_q;
    err_underflow_d = err_underflow_q || (bus.res_valid && fifo_empty);
    // Full queue with no pop this cycle; mispredict drops are not errors and need a pop anyway
    err_overflow_d  = err_overflow_q || (bus.push_valid && fifo_full && !res_fire);

    if (res_fire) begin
      upd_pc_d     = head.pc;
      upd_taken_d  = bus.res_taken;
      upd_target_d = bus.res_target;
      br_cnt_d     = sat_inc(br_cnt_q);
    end
    if (mp_now) begin
      redirect_pc_d = bus.res_taken ? bus.res_target : seq_next_pc(head.pc);
      mp_cnt_d      = sat_inc(mp_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= '0;
      upd_en_q        <= 1'b0;
      upd_pc_q        <= '0;
      upd_taken_q     <= 1'b0;
      upd_target_q    <= '0;
      br_cnt_q        <= '0;
      mp_cnt_q        <= '0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      mispredict_q    <= mispredict_d;
      redirect_pc_q   <= redirect_pc_d;
      upd_en_q        <= upd_en_d;
      upd_pc_q        <= upd_pc_d;
      upd_taken_q     <= upd_taken_d;
      upd_target_q    <= upd_target_d;
      br_cnt_q        <= br_cnt_d;
      mp_cnt_q        <= mp_cnt_d;
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  assign bus.push_ready  = !fifo_full;
  assign bus.mispredict  = mispredict_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.upd_en      = upd_en_q;
  assign bus.upd_pc      = upd_pc_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.upd_target  = upd_target_q;
  assign br_cnt          = br_cnt_q;
  assign mp_cnt          = mp_cnt_q;
  assign err_underflow   = err_underflow_q;
  assign err_overflow    = err_overflow_q;
endmodule
